zerosoc_uart_rx: RTL
====================

# zerosoc_uart_rx

Asynchronous serial receiver for the zerosoc UART. It takes the `uart_rx` line from the west padring input (`we_din[7]`), synchronises it and decodes 8-bit frames (start, 8 data bits LSB first, optional parity, 1 stop). Received bytes go to the SoC through a one-entry valid/ready holding register. Framing, parity, overrun and break conditions are reported as single-cycle pulses.

## Interface
Parameters:
- `DIV_W`, default 16: width of the baud divisor.
- `MIN_DIV`, default 4: smallest legal divisor; any smaller value is clamped to `MIN_DIV`.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `rx_i`  in  1  serial line from pad; idle high; asynchronous to `clk_i`.
- `enable_i`  in  1  receiver enable.
- `baud_div_i`  in  DIV_W  clock cycles per bit (D).
- `parity_en_i`  in  1  parity bit present.
- `parity_odd_i`  in  1  1 = odd parity, 0 = even parity.
- `rx_data_o`  out  8  received byte.
- `rx_valid_o`  out  1  `rx_data_o` holds an unread byte.
- `rx_ready_i`  in  1  consumer accepts the byte.
- `busy_o`  out  1  state is not IDLE.
- `frame_err_o`  out  1  pulse: stop bit sampled 0.
- `parity_err_o`  out  1  pulse: parity mismatch.
- `overrun_o`  out  1  pulse: new byte dropped because the holding register is full.
- `break_o`  out  1  pulse: all-zero frame, including the stop bit.

## Operation
- Synchroniser: two flops on `rx_i`, reset to 1. The output `rx_s` is the only internal view of the line.
- States: IDLE, START, DATA, PARITY, STOP. A down-counter `cnt` and a bit index `idx[2:0]` run the sampling.
- IDLE, when `enable_i`=1 and `rx_s`=0:
  - latch `Dl` = max(`baud_div_i`, `MIN_DIV`);
  - set `cnt` = (`Dl`>>1) − 1;
  - go to START.
  - Changes to `baud_div_i` during a frame are ignored.
- START at `cnt`==0:
  - `rx_s`=1: false start; return to IDLE with no flags raised;
  - otherwise set `cnt` = `Dl`−1 and `idx`=0, then go to DATA.
- DATA at `cnt`==0:
  - shift `rx_s` into bit `idx` (LSB first) and reload `cnt`;
  - after `idx`==7, go to PARITY if `parity_en_i`, else STOP.
  - `parity_en_i` and `parity_odd_i` are sampled at start detection.
- PARITY at `cnt`==0:
  - compute p = XOR(data) ^ `rx_s` ^ `parity_odd_i`; p≠0 is a parity error;
  - reload `cnt` and go to STOP.
- STOP at `cnt`==0, sample `rx_s`, then go to IDLE on the next cycle. The remaining half bit is not waited out, so back-to-back frames resync.
  - `rx_s`=1: deliver the byte. A parity error still delivers, and `parity_err_o` pulses in the delivery cycle.
  - `rx_s`=0: pulse `frame_err_o` and discard the byte. If the data byte is 0x00 and the parity bit (when enabled) is 0, also pulse `break_o`. Then stay in IDLE until `rx_s`=1 has been seen, so a held break produces exactly one `break_o`.
- Delivery into the holding register:
  - load when `rx_valid_o`=0, or when `rx_valid_o`=1 and `rx_ready_i`=1 in the same cycle (the simultaneous pop and push is lossless);
  - otherwise pulse `overrun_o`, drop the new byte and keep the old byte and its valid.
- Handshake:
  - `rx_valid_o` clears in the cycle after `rx_valid_o`=1 and `rx_ready_i`=1, unless a new byte loads in that same cycle;
  - `rx_data_o` is stable while `rx_valid_o`=1 and not accepted.
- `enable_i`=0: the next cycle forces IDLE and aborts any frame silently. The holding register and `rx_valid_o` are kept.

## Timing
- Reset values:
  - all outputs 0, with `rx_data_o`=0x00;
  - state IDLE, `cnt`=0, synchroniser flops 1.
- Start detection: rx_i low at clock edge t, `rx_s` low at t+2, START entered at t+3 (cycle E).
- Sample points:
  - start bit at E + (Dl>>1);
  - data bit k (k=0..7) at E + (Dl>>1) + (k+1)·Dl;
  - parity at E + (Dl>>1) + 9·Dl;
  - stop at the next bit slot after the last data or parity bit.
- `rx_valid_o` and all error pulses are registered and assert the cycle after the stop sample.
- Error pulses are exactly 1 cycle wide.
- `busy_o` is high from cycle E through the stop sample cycle.
- Reset asserted mid-frame: immediate return to reset values; no partial byte is delivered.

## Test plan
- D=16, 8N1, send 0x55 with `rx_ready_i`=1 → `rx_data_o`=0x55 and `rx_valid_o` high for 1 cycle, 10·16−8+4 ±1 cycles after the falling edge; no error pulses.
- D=16, low glitch of 6 cycles on `rx_i` → no `rx_valid_o`, no error pulses, `busy_o` returns low after 8 cycles.
- Send 0xA3 then 0x3C with `rx_ready_i`=0 → `rx_data_o` stays 0xA3, `overrun_o` pulses once; raising `rx_ready_i` clears `rx_valid_o` next cycle.
- Even parity enabled, send 0x07 with parity bit 0 → `rx_data_o`=0x07, `rx_valid_o` and `parity_err_o` pulse together.
- Hold `rx_i` low for 30 bit times, then release → one `frame_err_o` and one `break_o`, no byte delivered; next frame 0xFF is received correctly.
- `baud_div_i`=2 → operates at D=4. Assert `rst_ni`=0 during data bit 3 → all outputs 0 immediately; a following 0x81 frame decodes correctly.

Source files
------------

// File: rtl/zerosoc_uart_rx.sv
// zerosoc_uart_rx: 8-bit asynchronous serial receiver with optional parity,
// a one-entry valid/ready holding register and single-cycle error pulses.
`timescale 1ns/1ps
module zerosoc_uart_rx #(
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_i,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             busy_o,
    output logic             frame_err_o,
    output logic             parity_err_o,
    output logic             overrun_o,
    output logic             break_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [DIV_W-1:0] MIN_DIV_L = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ONE_L     = DIV_W'(1);

    // Line synchroniser; both flops idle high so reset never looks like a start bit.
    logic sync1_q, sync2_q;
    logic rx_s;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] dl_q, dl_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_en_q, par_en_d;
    logic             par_odd_q, par_odd_d;
    logic             par_bit_q, par_bit_d;
    logic             par_err_q, par_err_d;
    logic             wait_hi_q, wait_hi_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             brk_q, brk_d;
    logic [DIV_W-1:0] dl_clamp;

    assign rx_s     = sync2_q;
    assign dl_clamp = (baud_div_i < MIN_DIV_L) ? MIN_DIV_L : baud_div_i;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: frame sequencing, bit sampling, delivery and error pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dl_d      = dl_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        par_bit_d = par_bit_q;
        par_err_d = par_err_q;
        wait_hi_d = wait_hi_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        ovr_d     = 1'b0;
        brk_d     = 1'b0;

        // Consumer pop; a delivery in the same cycle below overrides it.
        if (valid_q && rx_ready_i) begin
            valid_d = 1'b0;
        end

        if (!enable_i) begin
            // Disabling aborts any frame silently; held byte is untouched.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // After a frame error, wait for the line to go idle first
                    // so a held break is reported only once.
                    if (wait_hi_q) begin
                        if (rx_s) begin
                            wait_hi_d = 1'b0;
                        end
                    end else if (!rx_s) begin
                        dl_d      = dl_clamp;
                        cnt_d     = (dl_clamp >> 1) - ONE_L;
                        par_en_d  = parity_en_i;
                        par_odd_d = parity_odd_i;
                        par_bit_d = 1'b0;
                        par_err_d = 1'b0;
                        state_d   = S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        if (rx_s) begin
                            // Glitch, not a start bit.
                            state_d = S_IDLE;
                        end else begin
                            cnt_d   = dl_q - ONE_L;
                            idx_d   = 3'd0;
                            state_d = S_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE_L;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_d[idx_q] = rx_s;
                        cnt_d          = dl_q - ONE_L;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE_L;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == '0) begin
                        par_bit_d = rx_s;
                        par_err_d = (^shift_q) ^ rx_s ^ par_odd_q;
                        cnt_d     = dl_q - ONE_L;
                        state_d   = S_STOP;
                    end else begin
                        cnt_d = cnt_q - ONE_L;
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        // Leave immediately so back-to-back frames resync on
                        // the next start edge instead of waiting out the stop bit.
                        state_d = S_IDLE;
                        if (rx_s) begin
                            perr_d = par_err_q;
                            if (!valid_q || rx_ready_i) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            ferr_d    = 1'b1;
                            brk_d     = (shift_q == 8'h00) && !par_bit_q;
                            wait_hi_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE_L;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dl_q      <= MIN_DIV_L;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            wait_hi_q <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dl_q      <= dl_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_bit_q <= par_bit_d;
            par_err_q <= par_err_d;
            wait_hi_q <= wait_hi_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
            brk_q     <= brk_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_err_o  = ferr_q;
    assign parity_err_o = perr_q;
    assign overrun_o    = ovr_q;
    assign break_o      = brk_q;

endmodule
